// File: rtl/rr_arbiter4_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: sizes, FSM state type,
// the post-reset last-winner value and a one-hot helper.
package rr_arbiter4_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Starting from 3 makes requester 0 the first in line after reset.
  localparam logic [IDX_W-1:0] LAST_WINNER_RST = 2'd3;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_arbiter4_pick.sv
// Combinational round-robin selector: first set request bit searching upward
// from last_winner+1, wrapping around to last_winner itself.
module rr_pick4
  import rr_arbiter4_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_winner,
  output logic               found,
  output logic [IDX_W-1:0]   index
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    // NOTE: every output gets a default before the search loop, so no path
    // leaves a value unassigned and no latch is inferred.
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last_winner + IDX_W'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a bounded hold time per grant and a
// one-cycle timeout pulse when a grant is revoked by that bound.
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req,
  input  logic                done,
  output logic [NUM_REQ-1:0]  grant,
  output logic                grant_valid,
  output logic [IDX_W-1:0]    owner,
  output logic                timeout
);

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t            state;
  logic [3:0]        hold_cnt;
  logic [IDX_W-1:0]  last_winner;

  logic              pick_found;
  logic [IDX_W-1:0]  pick_index;
  logic              owner_req;
  logic              hold_limit;
  logic              release_now;

  rr_pick4 u_pick (
    .req         (req),
    .last_winner (last_winner),
    .found       (pick_found),
    .index       (pick_index)
  );

  assign owner_req   = req[owner];
  assign hold_limit  = (hold_cnt == HOLD_LAST);
  assign release_now = done || !owner_req || hold_limit;

  // grant is one-hot exactly while in GRANT, so the state bit is the valid flag.
  assign grant_valid = (state == GRANT);

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values; the timeout default below is overridden later
  // in the same block on a limit-driven release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      owner       <= '0;
      timeout     <= 1'b0;
      hold_cnt    <= '0;
      last_winner <= LAST_WINNER_RST;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            state    <= GRANT;
            grant    <= idx_to_onehot(pick_index);
            owner    <= pick_index;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (release_now) begin
            state       <= IDLE;
            grant       <= '0;
            owner       <= '0;
            hold_cnt    <= '0;
            last_winner <= owner;
            // A voluntary release at the limit edge is not a revocation.
            timeout     <= hold_limit && !done && owner_req;
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          owner <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4: directed vector table, hand-written
// hold-limit and reset sequences, and a randomized invariant sweep.
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] owner;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       timeout;
  } vec_t;

  vec_t vecs[$];

  rr_arbiter4 #(.MAX_HOLD(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .owner       (owner),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] o,
                           input logic t);
    check({tag, ".grant"},   32'(grant),       32'(g));
    check({tag, ".valid"},   32'(grant_valid), 32'(g != 4'b0000));
    check({tag, ".owner"},   32'(owner),       32'(o));
    check({tag, ".timeout"}, 32'(timeout),     32'(t));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic [3:0] r, input logic d, input logic [3:0] g,
                              input logic [1:0] o, input logic t);
    vec_t v;
    v.req     = r;
    v.done    = d;
    v.grant   = g;
    v.owner   = o;
    v.timeout = t;
    vecs.push_back(v);
  endfunction

  initial begin
    // All requesting, done in every third grant cycle: owners 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      logic [3:0] oh;
      oh = 4'b0001 << (k % 4);
      for (int c = 0; c < 3; c++) add(4'hF, 1'b0, oh, 2'(k % 4), 1'b0);
      add(4'hF, 1'b1, 4'b0000, 2'd0, 1'b0);
    end
    // Owner 1, other bits change, then req[1] drops with 1001 pending.
    add(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0);
    add(4'b1011, 1'b0, 4'b0010, 2'd1, 1'b0);
    add(4'b0111, 1'b0, 4'b0010, 2'd1, 1'b0);
    add(4'b1001, 1'b0, 4'b0000, 2'd0, 1'b0);
    add(4'b1001, 1'b0, 4'b1000, 2'd3, 1'b0);
    add(4'b1001, 1'b1, 4'b0000, 2'd0, 1'b0);
    // done in IDLE is ignored.
    add(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);
    add(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);
    add(4'b0001, 1'b1, 4'b0001, 2'd0, 1'b0);
    add(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);

    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    step();
    step();
    check_out("reset", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;
    step();
    check_out("idle_noreq", 4'b0000, 2'd0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      req  = vecs[i].req;
      done = vecs[i].done;
      step();
      check_out($sformatf("vec%0d", i), vecs[i].grant, vecs[i].owner, vecs[i].timeout);
    end

    // Hold limit with a steady single requester.
    req  = 4'b0100;
    done = 1'b0;
    step();
    check_out("hold.c0", 4'b0100, 2'd2, 1'b0);
    for (int i = 1; i < 15; i++) begin
      step();
      check_out($sformatf("hold.c%0d", i), 4'b0100, 2'd2, 1'b0);
    end
    step();
    check_out("hold.expire", 4'b0000, 2'd0, 1'b1);
    step();
    check_out("hold.regrant", 4'b0100, 2'd2, 1'b0);
    req = 4'b0000;
    step();
    check_out("hold.drop", 4'b0000, 2'd0, 1'b0);

    // done coinciding with the limit edge is a normal release.
    req = 4'b0001;
    step();
    check_out("lim.c0", 4'b0001, 2'd0, 1'b0);
    for (int i = 1; i < 15; i++) begin
      step();
      check_out($sformatf("lim.c%0d", i), 4'b0001, 2'd0, 1'b0);
    end
    done = 1'b1;
    step();
    check_out("lim.done", 4'b0000, 2'd0, 1'b0);
    done = 1'b0;
    req  = 4'b0000;
    step();
    check_out("lim.after", 4'b0000, 2'd0, 1'b0);

    // Asynchronous reset while owner 2 holds the grant.
    req = 4'b0100;
    step();
    check_out("rst.pre", 4'b0100, 2'd2, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check_out("rst.async", 4'b0000, 2'd0, 1'b0);
    step();
    rst = 1'b0;
    req = 4'b0110;
    step();
    check_out("rst.first", 4'b0010, 2'd1, 1'b0);

    // Random traffic: structural invariants every cycle.
    for (int n = 0; n < 10000; n++) begin
      logic [1:0] exp_o;
      req  = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 7) == 0);
      step();
      exp_o = 2'd0;
      for (int b = 0; b < 4; b++) if (grant[b]) exp_o = 2'(b);
      check("rand.onehot0", 32'($onehot0(grant)), 32'd1);
      check("rand.valid",   32'(grant_valid),     32'(grant != 4'b0000));
      check("rand.owner",   32'(owner),           32'(exp_o));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 Parameter: MAX_HOLD, default 15, maximum number of consecutive cycles one grant is held (legal range 1..15).
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: req  input  4  request lines, bit i = requester i.
REQ-005 Port: done  input  1  current owner releases grant.
REQ-006 Port: grant  output  4  registered one-hot grant, or 4'b0000 when no owner; feeds the downstream 4-to-2 encoder.
REQ-007 Port: grant_valid  output  1  high exactly when grant is one-hot.
REQ-008 Port: owner  output  2  registered binary index of current grant, 2'b00 when grant_valid is low.
REQ-009 Port: timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-010 The block SHALL implement two states: IDLE (grant 0000) and GRANT (grant one-hot).
REQ-011 In IDLE with req != 0, the block SHALL select the first set req bit searching upward from (last_winner+1) mod 4, wrapping, and enter GRANT on that edge.
REQ-012 Grant latency SHALL be one cycle: req sampled at edge n -> grant, grant_valid, owner valid after edge n.
REQ-013 In IDLE with req == 0, outputs SHALL stay grant=0000, grant_valid=0, owner=00.
REQ-014 On entering GRANT, hold counter SHALL load 0; it SHALL increment by 1 each GRANT cycle, 4 bits wide, no wrap (release occurs first).
REQ-015 GRANT SHALL exit to IDLE at the edge where any of: done=1; req[owner]=0; hold counter == MAX_HOLD-1.
REQ-016 On exit, last_winner SHALL load owner; grant SHALL read 0000 for exactly one cycle before any new grant.
REQ-017 timeout SHALL pulse for the cycle after the exit edge only if the exit cause is the hold limit and done=0 and req[owner]=1 at that edge.
REQ-018 Simultaneous done and hold-limit SHALL be treated as a normal release: no timeout pulse.
REQ-019 Changes to req bits other than req[owner] during GRANT SHALL NOT affect grant.
REQ-020 done asserted in IDLE SHALL be ignored.
REQ-021 grant SHALL never have more than one bit set in any cycle.

Reset
REQ-022 While rst=1: state IDLE, grant=0000, grant_valid=0, owner=00, timeout=0, hold counter=0, last_winner=2'd3 (requester 0 wins first).
REQ-023 rst asserted mid-GRANT SHALL clear grant asynchronously, without waiting for a clock edge.
REQ-024 After rst deasserts, the first grant SHALL be issued one edge after req is sampled non-zero.

Structure
REQ-025 A shared package SHALL hold NUM_REQ=4, the state typedef {IDLE, GRANT}, and the reset value of last_winner.
REQ-026 Round-robin selection SHALL be a combinational sub-module rr_pick4 (inputs req, last_winner; outputs found, index); all registers SHALL reside in rr_arbiter4.

Verification
REQ-027 Reset then req=1111 held, done pulsed every 3rd grant cycle -> owners 0,1,2,3,0 in order, one 0000 cycle between each.
REQ-028 req=0100 only, done never, MAX_HOLD=15 -> grant=0100 for 15 cycles, timeout pulses once, 0000 one cycle, grant=0100 again.
REQ-029 Owner 1 granted, req[1] drops -> grant 0000 next cycle, no timeout; with req=1001 pending, next owner is 3.
REQ-030 done=1 at the same edge the hold counter reaches MAX_HOLD-1 -> release, timeout stays 0.
REQ-031 rst pulsed mid-GRANT (owner 2) -> grant 0000 immediately; after release with req=0110, first owner is 1.
REQ-032 Random req/done for 10k cycles -> grant always one-hot or zero, grant_valid equals (grant!=0), owner encodes grant.
